// File: rtl/ysyx_25060173_ifu.sv
// Instruction fetch unit: one outstanding read, out_valid one cycle after the response, next request one cycle after the out handshake.
// Backpressure: mem_req_addr is held until mem_req_ready; out_inst/out_pc are held until out_ready.
module ysyx_25060173_ifu #(
    parameter logic [31:0] RESET_PC         = 32'h8000_0000,
    parameter logic [31:0] FETCH_COUNT_INIT = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [31:0] mem_req_addr,
    input  logic        mem_rsp_valid,
    input  logic [31:0] mem_rsp_data,
    input  logic        mem_rsp_err,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_inst,
    output logic [31:0] out_pc,
    output logic        fault,
    output logic [31:0] fault_pc,
    output logic [31:0] fetch_count
);

    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_WAIT  = 3'd2,
        S_HOLD  = 3'd3,
        S_FAULT = 3'd4
    } state_t;

    state_t      r_state, w_state_nxt;
    logic [31:0] r_pc, w_pc_nxt;
    logic        r_redir_pend, w_redir_pend_nxt;
    logic [31:0] r_redir_pc, w_redir_pc_nxt;
    logic [31:0] r_out_inst, w_out_inst_nxt;
    logic [31:0] r_out_pc, w_out_pc_nxt;
    logic [31:0] r_fault_pc, w_fault_pc_nxt;
    logic [31:0] r_fetch_count, w_fetch_count_nxt;

    // A redirect arriving in the same cycle as the response still kills that response.
    logic        w_pend_eff;
    logic [31:0] w_redir_tgt;
    assign w_pend_eff  = r_redir_pend | redirect_valid;
    assign w_redir_tgt = redirect_valid ? redirect_pc : r_redir_pc;

    assign mem_req_addr = r_pc;
    assign out_inst     = r_out_inst;
    assign out_pc       = r_out_pc;
    assign fault_pc     = r_fault_pc;
    assign fetch_count  = r_fetch_count;

    always_comb begin
        w_state_nxt       = r_state;
        w_pc_nxt          = r_pc;
        w_redir_pend_nxt  = r_redir_pend;
        w_redir_pc_nxt    = r_redir_pc;
        w_out_inst_nxt    = r_out_inst;
        w_out_pc_nxt      = r_out_pc;
        w_fault_pc_nxt    = r_fault_pc;
        w_fetch_count_nxt = r_fetch_count;
        mem_req_valid     = 1'b0;
        out_valid         = 1'b0;
        fault             = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_state_nxt = S_REQ;
                if (redirect_valid) begin
                    if (redirect_pc[1:0] != 2'b00) begin
                        w_fault_pc_nxt = redirect_pc;
                        w_state_nxt    = S_FAULT;
                    end else begin
                        w_pc_nxt = redirect_pc;
                    end
                end
            end
            S_REQ: begin
                mem_req_valid = 1'b1;
                if (redirect_valid) begin
                    w_redir_pend_nxt = 1'b1;
                    w_redir_pc_nxt   = redirect_pc;
                end
                if (mem_req_ready) begin
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (mem_rsp_valid) begin
                    if (w_pend_eff) begin
                        w_redir_pend_nxt = 1'b0;
                        if (w_redir_tgt[1:0] != 2'b00) begin
                            w_fault_pc_nxt = w_redir_tgt;
                            w_state_nxt    = S_FAULT;
                        end else begin
                            w_pc_nxt    = w_redir_tgt;
                            w_state_nxt = S_REQ;
                        end
                    end else if (mem_rsp_err) begin
                        w_fault_pc_nxt = r_pc;
                        w_state_nxt    = S_FAULT;
                    end else begin
                        w_out_inst_nxt = mem_rsp_data;
                        w_out_pc_nxt   = r_pc;
                        w_state_nxt    = S_HOLD;
                    end
                end else if (redirect_valid) begin
                    w_redir_pend_nxt = 1'b1;
                    w_redir_pc_nxt   = redirect_pc;
                end
            end
            S_HOLD: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_fetch_count_nxt = r_fetch_count + 32'd1;
                end
                if (redirect_valid) begin
                    if (redirect_pc[1:0] != 2'b00) begin
                        w_fault_pc_nxt = redirect_pc;
                        w_state_nxt    = S_FAULT;
                    end else begin
                        w_pc_nxt    = redirect_pc;
                        w_state_nxt = S_REQ;
                    end
                end else if (out_ready) begin
                    w_pc_nxt    = r_pc + 32'd4;
                    w_state_nxt = S_REQ;
                end
            end
            S_FAULT: begin
                fault = 1'b1;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_pc          <= RESET_PC;
            r_redir_pend  <= 1'b0;
            r_redir_pc    <= RESET_PC;
            r_out_inst    <= NOP_INST;
            r_out_pc      <= RESET_PC;
            r_fault_pc    <= 32'h0000_0000;
            r_fetch_count <= FETCH_COUNT_INIT;
        end else begin
            r_state       <= w_state_nxt;
            r_pc          <= w_pc_nxt;
            r_redir_pend  <= w_redir_pend_nxt;
            r_redir_pc    <= w_redir_pc_nxt;
            r_out_inst    <= w_out_inst_nxt;
            r_out_pc      <= w_out_pc_nxt;
            r_fault_pc    <= w_fault_pc_nxt;
            r_fetch_count <= w_fetch_count_nxt;
        end
    end

endmodule

// File: tb/tb_ysyx_25060173_ifu.sv
// Bench for the fetch unit: directed sequences, a HOLD-phase vector table, and random traffic vs a transaction-level model.
// A second instance with a preset fetch counter shares all inputs to observe counter wrap.
module tb_ysyx_25060173_ifu;

    localparam logic [31:0] RST_PC = 32'h8000_0000;

    logic        clk;
    logic        rst_n;
    logic        mem_req_ready;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_data;
    logic        mem_rsp_err;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_ready;

    logic        mem_req_valid, out_valid, fault;
    logic [31:0] mem_req_addr, out_inst, out_pc, fault_pc, fetch_count;

    logic        w_req_vld, w_out_vld, w_fault;
    logic [31:0] w_req_addr, w_out_inst, w_out_pc, w_fault_pc, w_fetch_count;

    int checks   = 0;
    int failures = 0;

    ysyx_25060173_ifu #(.RESET_PC(RST_PC)) dut (
        .clk(clk), .rst_n(rst_n),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data), .mem_rsp_err(mem_rsp_err),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst), .out_pc(out_pc),
        .fault(fault), .fault_pc(fault_pc), .fetch_count(fetch_count)
    );

    ysyx_25060173_ifu #(.RESET_PC(RST_PC), .FETCH_COUNT_INIT(32'hFFFF_FFFE)) u_wrap (
        .clk(clk), .rst_n(rst_n),
        .mem_req_valid(w_req_vld), .mem_req_ready(mem_req_ready), .mem_req_addr(w_req_addr),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data), .mem_rsp_err(mem_rsp_err),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .out_valid(w_out_vld), .out_ready(out_ready), .out_inst(w_out_inst), .out_pc(w_out_pc),
        .fault(w_fault), .fault_pc(w_fault_pc), .fetch_count(w_fetch_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached, failures=%0d", failures);
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        redir;
        logic [31:0] tgt;
        logic        ordy;
        logic        exp_fault;
        logic        exp_ovld;
        logic [31:0] exp_addr;
        logic [31:0] exp_cnt;
        logic [31:0] exp_fpc;
    } vec_t;

    vec_t vecs[6];

    // random-phase model state
    logic        m_hold, m_infl, m_dirty;
    logic [31:0] m_exp_addr, m_addr_if, m_hold_pc, m_redir_tgt, m_cnt;
    int          m_delay;
    int          bad;

    task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] memf(input logic [31:0] a);
        return (a * 32'h9E37_79B9) ^ 32'h0000_0013;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_in();
        mem_req_ready  = 1'b0;
        mem_rsp_valid  = 1'b0;
        mem_rsp_data   = 32'h0;
        mem_rsp_err    = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        out_ready      = 1'b0;
    endtask

    // Leaves the DUT in its request state (one IDLE cycle after release).
    task automatic do_reset();
        clr_in();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic check_reset_vals(input string tag);
        chk1 ({tag, "_req_vld"},  mem_req_valid, 1'b0);
        chk32({tag, "_req_addr"}, mem_req_addr,  RST_PC);
        chk1 ({tag, "_out_vld"},  out_valid,     1'b0);
        chk32({tag, "_out_inst"}, out_inst,      32'h0000_0013);
        chk32({tag, "_out_pc"},   out_pc,        RST_PC);
        chk1 ({tag, "_fault"},    fault,         1'b0);
        chk32({tag, "_fault_pc"}, fault_pc,      32'h0);
        chk32({tag, "_count"},    fetch_count,   32'h0);
    endtask

    task automatic fetch_to_hold(input logic [31:0] d);
        int n = 0;
        while (!mem_req_valid && n < 10) begin
            tick();
            n++;
        end
        chk1("fetch_req_vld", mem_req_valid, 1'b1);
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = d;
        tick();
        mem_rsp_valid = 1'b0;
    endtask

    initial begin
        vecs[0] = '{1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 32'h8000_0004, 32'd1, 32'h0};
        vecs[1] = '{1'b1, 32'h8000_0040, 1'b1, 1'b0, 1'b0, 32'h8000_0040, 32'd1, 32'h0};
        vecs[2] = '{1'b1, 32'h8000_0200, 1'b0, 1'b0, 1'b0, 32'h8000_0200, 32'd0, 32'h0};
        vecs[3] = '{1'b1, 32'h8000_0102, 1'b0, 1'b1, 1'b0, 32'h8000_0000, 32'd0, 32'h8000_0102};
        vecs[4] = '{1'b1, 32'h8000_0101, 1'b0, 1'b1, 1'b0, 32'h8000_0000, 32'd0, 32'h8000_0101};
        vecs[5] = '{1'b0, 32'h0000_0000, 1'b0, 1'b0, 1'b1, 32'h8000_0000, 32'd0, 32'h0};

        clr_in();
        rst_n = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_vals("por");

        // basic fetch and handshake
        do_reset();
        chk1 ("b_req_vld", mem_req_valid, 1'b1);
        chk32("b_req_addr", mem_req_addr, 32'h8000_0000);
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        chk1("b_wait_req_vld", mem_req_valid, 1'b0);
        chk1("b_wait_out_vld", out_valid, 1'b0);
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = 32'h0010_0073;
        tick();
        mem_rsp_valid = 1'b0;
        chk1 ("b_out_vld", out_valid, 1'b1);
        chk32("b_out_inst", out_inst, 32'h0010_0073);
        chk32("b_out_pc", out_pc, 32'h8000_0000);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk1 ("b_next_req_vld", mem_req_valid, 1'b1);
        chk32("b_next_addr", mem_req_addr, 32'h8000_0004);
        chk32("b_count", fetch_count, 32'd1);
        chk32("b_wrap_count", w_fetch_count, 32'hFFFF_FFFF);

        // second handshake, then an access fault at 0x8000_0008
        fetch_to_hold(32'h0000_0517);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk32("f_wrap_zero", w_fetch_count, 32'h0);
        chk32("f_addr", mem_req_addr, 32'h8000_0008);
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b1;
        mem_rsp_err   = 1'b1;
        tick();
        mem_rsp_valid = 1'b0;
        mem_rsp_err   = 1'b0;
        chk1 ("f_fault", fault, 1'b1);
        chk32("f_fault_pc", fault_pc, 32'h8000_0008);
        chk1 ("f_out_vld", out_valid, 1'b0);
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            redirect_valid = ($urandom_range(0, 1) == 1);
            redirect_pc    = 32'h8000_0200;
            mem_req_ready  = 1'b1;
            mem_rsp_valid  = ($urandom_range(0, 1) == 1);
            tick();
            if (mem_req_valid || out_valid || !fault) bad++;
        end
        clr_in();
        chk32("f_frozen_violations", bad, 32'd0);
        chk32("f_count_frozen", fetch_count, 32'd2);
        chk32("f_fault_pc_held", fault_pc, 32'h8000_0008);
        rst_n = 1'b0;
        #1;
        check_reset_vals("flt_rst");

        // stalled request with a redirect: old word discarded
        do_reset();
        for (int i = 0; i < 5; i++) begin
            chk1 ("s_req_vld", mem_req_valid, 1'b1);
            chk32("s_addr_stable", mem_req_addr, 32'h8000_0000);
            redirect_valid = (i == 2);
            redirect_pc    = 32'h8000_0100;
            mem_rsp_valid  = (i == 3);
            tick();
        end
        clr_in();
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = 32'hBAD0_0013;
        tick();
        mem_rsp_valid = 1'b0;
        chk1 ("s_old_out_vld", out_valid, 1'b0);
        chk1 ("s_req_vld2", mem_req_valid, 1'b1);
        chk32("s_redir_addr", mem_req_addr, 32'h8000_0100);
        fetch_to_hold(32'h1111_2222);
        chk32("s_new_pc", out_pc, 32'h8000_0100);
        chk32("s_new_inst", out_inst, 32'h1111_2222);

        // HOLD stability, stray response ignored, redirect with handshake
        do_reset();
        fetch_to_hold(32'h0000_0297);
        for (int i = 0; i < 4; i++) begin
            mem_rsp_valid = (i == 1);
            mem_rsp_data  = 32'hFFFF_FFFF;
            tick();
            chk1 ("h_out_vld", out_valid, 1'b1);
            chk32("h_out_inst", out_inst, 32'h0000_0297);
            chk32("h_out_pc", out_pc, 32'h8000_0000);
        end
        clr_in();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_0040;
        out_ready      = 1'b1;
        tick();
        clr_in();
        chk1 ("h_out_vld_drop", out_valid, 1'b0);
        chk32("h_count", fetch_count, 32'd1);
        chk1 ("h_req_vld", mem_req_valid, 1'b1);
        chk32("h_redir_addr", mem_req_addr, 32'h8000_0040);

        // HOLD-phase vector table
        for (int i = 0; i < 6; i++) begin
            do_reset();
            fetch_to_hold(memf(i));
            redirect_valid = vecs[i].redir;
            redirect_pc    = vecs[i].tgt;
            out_ready      = vecs[i].ordy;
            tick();
            clr_in();
            chk1 ($sformatf("vec%0d_fault", i),    fault,         vecs[i].exp_fault);
            chk1 ($sformatf("vec%0d_out_vld", i),  out_valid,     vecs[i].exp_ovld);
            chk1 ($sformatf("vec%0d_req_vld", i),  mem_req_valid, !vecs[i].exp_fault && !vecs[i].exp_ovld);
            chk32($sformatf("vec%0d_addr", i),     mem_req_addr,  vecs[i].exp_addr);
            chk32($sformatf("vec%0d_count", i),    fetch_count,   vecs[i].exp_cnt);
            chk32($sformatf("vec%0d_fault_pc", i), fault_pc,      vecs[i].exp_fpc);
        end

        // random traffic against a transaction-level model
        do_reset();
        m_exp_addr = RST_PC;
        m_hold  = 1'b0;
        m_infl  = 1'b0;
        m_dirty = 1'b0;
        m_cnt   = 32'h0;
        m_delay = 0;
        m_addr_if   = 32'h0;
        m_hold_pc   = 32'h0;
        m_redir_tgt = 32'h0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            chk1("r_req_vld", mem_req_valid, !m_hold && !m_infl);
            if (!m_hold && !m_infl) chk32("r_req_addr", mem_req_addr, m_exp_addr);
            chk1("r_out_vld", out_valid, m_hold);
            if (m_hold) begin
                chk32("r_out_pc", out_pc, m_hold_pc);
                chk32("r_out_inst", out_inst, memf(m_hold_pc));
            end
            chk32("r_count", fetch_count, m_cnt);

            mem_req_ready = ($urandom_range(0, 2) != 0);
            mem_rsp_valid = 1'b0;
            mem_rsp_err   = 1'b0;
            mem_rsp_data  = $urandom;
            if (m_infl) begin
                if (m_delay == 0) begin
                    mem_rsp_valid = 1'b1;
                    mem_rsp_data  = memf(m_addr_if);
                end else begin
                    m_delay--;
                end
            end else if ($urandom_range(0, 15) == 0) begin
                mem_rsp_valid = 1'b1;
            end
            out_ready      = ($urandom_range(0, 1) == 1);
            redirect_valid = ($urandom_range(0, 9) == 0);
            redirect_pc    = RST_PC + ($urandom_range(0, 255) << 2);

            if (m_hold) begin
                if (out_ready) m_cnt = m_cnt + 32'd1;
                if (redirect_valid) begin
                    m_exp_addr = redirect_pc;
                    m_hold     = 1'b0;
                end else if (out_ready) begin
                    m_exp_addr = m_hold_pc + 32'd4;
                    m_hold     = 1'b0;
                end
            end else begin
                if (redirect_valid) begin
                    m_dirty     = 1'b1;
                    m_redir_tgt = redirect_pc;
                end
                if (m_infl) begin
                    if (mem_rsp_valid) begin
                        m_infl = 1'b0;
                        if (m_dirty) begin
                            m_exp_addr = m_redir_tgt;
                            m_dirty    = 1'b0;
                        end else begin
                            m_hold    = 1'b1;
                            m_hold_pc = m_addr_if;
                        end
                    end
                end else if (mem_req_ready) begin
                    m_infl    = 1'b1;
                    m_addr_if = m_exp_addr;
                    m_delay   = int'($urandom_range(0, 3));
                end
            end
            tick();
        end
        clr_in();
        chk32("r_wrap_count", w_fetch_count, m_cnt + 32'hFFFF_FFFE);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
